if_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.

---
 rtl/if_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Issues word fetches over a req/ack handshake and drops wrong-path data after a redirect.
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    // Redirect target parked while a wrong-path request is still outstanding,
    // so mem_addr_o never moves before the ack.
    logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] target_pc;
    logic              if_id_ready;
    logic              ack_live;

    assign target_pc   = redirect_pc_i & ~ADDR_W'(3);
    assign if_id_ready = !valid_q || !stall_i;
    assign ack_live    = mem_ack_i && (state_q != IDLE);

    // NOTE: every next-state variable gets its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        flush_pc_d   = flush_pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        valid_d      = valid_q;

        if (redirect_i) begin
            valid_d      = 1'b0;
            inst_d       = '0;
            skid_valid_d = 1'b0;
            if (state_q == IDLE || ack_live) begin
                state_d    = BUSY;
                fetch_pc_d = target_pc;
            end else begin
                state_d    = FLUSH;
                flush_pc_d = target_pc;
            end
        end else begin
            if (!stall_i) begin
                valid_d = 1'b0;
                inst_d  = '0;
            end

            case (state_q)
                IDLE: begin
                    if (!skid_valid_q) begin
                        state_d = BUSY;
                    end else if (!stall_i) begin
                        pc_d         = skid_pc_q;
                        inst_d       = skid_inst_q;
                        valid_d      = 1'b1;
                        skid_valid_d = 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        if (if_id_ready) begin
                            pc_d    = fetch_pc_q;
                            inst_d  = mem_data_i;
                            valid_d = 1'b1;
                        end else begin
                            // Decode is stalled on a live word: park this one and pause fetching.
                            skid_valid_d = 1'b1;
                            skid_pc_d    = fetch_pc_q;
                            skid_inst_d  = mem_data_i;
                            state_d      = IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (mem_ack_i) begin
                        state_d    = BUSY;
                        fetch_pc_d = flush_pc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            flush_pc_q   <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
            pc_q         <= '0;
            inst_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            flush_pc_q   <= flush_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
        end
    end

    assign mem_req_o    = (state_q != IDLE);
    assign mem_addr_o   = fetch_pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule
